// File: rtl/axi_mmio_arbiter.sv
// rtl/axi_mmio_arbiter.sv - two-master round-robin AXI4-Lite arbiter, one transaction in flight
module axi_mmio_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                        aclk,
  input  logic                        arst_n,
  // upstream masters 0 and 1
  input  logic [1:0][ADDR_W-1:0]      M_AXI_awaddr,
  input  logic [1:0][2:0]             M_AXI_awprot,
  input  logic [1:0]                  M_AXI_awvalid,
  output logic [1:0]                  M_AXI_awready,
  input  logic [1:0][DATA_W-1:0]      M_AXI_wdata,
  input  logic [1:0][DATA_W/8-1:0]    M_AXI_wstrb,
  input  logic [1:0]                  M_AXI_wvalid,
  output logic [1:0]                  M_AXI_wready,
  output logic [1:0][1:0]             M_AXI_bresp,
  output logic [1:0]                  M_AXI_bvalid,
  input  logic [1:0]                  M_AXI_bready,
  input  logic [1:0][ADDR_W-1:0]      M_AXI_araddr,
  input  logic [1:0][2:0]             M_AXI_arprot,
  input  logic [1:0]                  M_AXI_arvalid,
  output logic [1:0]                  M_AXI_arready,
  output logic [1:0][DATA_W-1:0]      M_AXI_rdata,
  output logic [1:0][1:0]             M_AXI_rresp,
  output logic [1:0]                  M_AXI_rvalid,
  input  logic [1:0]                  M_AXI_rready,
  // downstream slave port
  output logic [ADDR_W-1:0]           S_AXI_awaddr,
  output logic [2:0]                  S_AXI_awprot,
  output logic                        S_AXI_awvalid,
  input  logic                        S_AXI_awready,
  output logic [DATA_W-1:0]           S_AXI_wdata,
  output logic [DATA_W/8-1:0]         S_AXI_wstrb,
  output logic                        S_AXI_wvalid,
  input  logic                        S_AXI_wready,
  input  logic [1:0]                  S_AXI_bresp,
  input  logic                        S_AXI_bvalid,
  output logic                        S_AXI_bready,
  output logic [ADDR_W-1:0]           S_AXI_araddr,
  output logic [2:0]                  S_AXI_arprot,
  output logic                        S_AXI_arvalid,
  input  logic                        S_AXI_arready,
  input  logic [DATA_W-1:0]           S_AXI_rdata,
  input  logic [1:0]                  S_AXI_rresp,
  input  logic                        S_AXI_rvalid,
  output logic                        S_AXI_rready,
  // status
  output logic [1:0]                  grant,
  output logic                        busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_RESP = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        busy_q, busy_d;
  logic        last_q, last_d;       // index of the master that owned the port last
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  logic [1:0]  req;
  logic        win;
  logic        gidx;
  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign gidx  = grant_q[1];
  assign grant = grant_q;
  assign busy  = busy_q;

  assign aw_hs = S_AXI_awvalid & S_AXI_awready;
  assign w_hs  = S_AXI_wvalid  & S_AXI_wready;
  assign b_hs  = S_AXI_bvalid  & S_AXI_bready;
  assign ar_hs = S_AXI_arvalid & S_AXI_arready;
  assign r_hs  = S_AXI_rvalid  & S_AXI_rready;

  // Round-robin winner: a lone requester wins, a tie goes to the master that did not own the port last
  always_comb begin
    req = M_AXI_awvalid | M_AXI_arvalid;
    if (req == 2'b11) begin
      win = ~last_q;
    end else begin
      win = req[1];
    end
  end

  // Next-state logic: arbitrate in IDLE, then follow the granted transaction to its response
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    last_d    = last_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          grant_d   = win ? 2'b10 : 2'b01;
          busy_d    = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          // a write beats a read from the same master; the read stays pending upstream
          state_d   = M_AXI_awvalid[win] ? WR_ADDR : RD_ADDR;
        end
      end
      WR_ADDR: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (b_hs) begin
          state_d   = IDLE;
          grant_d   = 2'b00;
          busy_d    = 1'b0;
          last_d    = gidx;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      RD_ADDR: begin
        if (ar_hs) begin
          state_d = RD_RESP;
        end
      end
      RD_RESP: begin
        if (r_hs) begin
          state_d = IDLE;
          grant_d = 2'b00;
          busy_d  = 1'b0;
          last_d  = gidx;
        end
      end
      default: begin
        state_d   = IDLE;
        grant_d   = 2'b00;
        busy_d    = 1'b0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
      end
    endcase
  end

  // State registers; reset abandons any transaction and favours master 0 on the first tie
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      busy_q    <= 1'b0;
      last_q    <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      last_q    <= last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Channel routing: only the granted master is connected, everything else reads as zero
  always_comb begin
    S_AXI_awaddr  = '0;
    S_AXI_awprot  = '0;
    S_AXI_awvalid = 1'b0;
    S_AXI_wdata   = '0;
    S_AXI_wstrb   = '0;
    S_AXI_wvalid  = 1'b0;
    S_AXI_bready  = 1'b0;
    S_AXI_araddr  = '0;
    S_AXI_arprot  = '0;
    S_AXI_arvalid = 1'b0;
    S_AXI_rready  = 1'b0;
    M_AXI_awready = '0;
    M_AXI_wready  = '0;
    M_AXI_bresp   = '0;
    M_AXI_bvalid  = '0;
    M_AXI_arready = '0;
    M_AXI_rdata   = '0;
    M_AXI_rresp   = '0;
    M_AXI_rvalid  = '0;
    if (grant_q != 2'b00) begin
      S_AXI_awaddr = M_AXI_awaddr[gidx];
      S_AXI_awprot = M_AXI_awprot[gidx];
      S_AXI_wdata  = M_AXI_wdata[gidx];
      S_AXI_wstrb  = M_AXI_wstrb[gidx];
      S_AXI_araddr = M_AXI_araddr[gidx];
      S_AXI_arprot = M_AXI_arprot[gidx];
    end
    case (state_q)
      WR_ADDR: begin
        // a channel already accepted downstream is masked so it cannot handshake twice
        S_AXI_awvalid       = M_AXI_awvalid[gidx] & ~aw_done_q;
        S_AXI_wvalid        = M_AXI_wvalid[gidx] & ~w_done_q;
        M_AXI_awready[gidx] = S_AXI_awready & ~aw_done_q;
        M_AXI_wready[gidx]  = S_AXI_wready & ~w_done_q;
      end
      WR_RESP: begin
        M_AXI_bvalid[gidx] = S_AXI_bvalid;
        M_AXI_bresp[gidx]  = S_AXI_bresp;
        S_AXI_bready       = M_AXI_bready[gidx];
      end
      RD_ADDR: begin
        S_AXI_arvalid       = M_AXI_arvalid[gidx];
        M_AXI_arready[gidx] = S_AXI_arready;
      end
      RD_RESP: begin
        M_AXI_rvalid[gidx] = S_AXI_rvalid;
        M_AXI_rdata[gidx]  = S_AXI_rdata;
        M_AXI_rresp[gidx]  = S_AXI_rresp;
        S_AXI_rready       = M_AXI_rready[gidx];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_mmio_arbiter.sv
// tb/tb_axi_mmio_arbiter.sv - random and directed checks of axi_mmio_arbiter against a transaction model
module tb_axi_mmio_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] KEY = 32'hA5C3_0F96;

  logic aclk = 1'b0;
  logic arst_n = 1'b0;
  always #5 aclk = ~aclk;

  // master-side stimulus and DUT upstream outputs
  logic [1:0][AW-1:0] m_awaddr, m_araddr;
  logic [1:0][2:0]    m_awprot, m_arprot;
  logic [1:0][DW-1:0] m_wdata;
  logic [1:0][3:0]    m_wstrb;
  logic [1:0]         m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic [1:0]         up_awready, up_wready, up_bvalid, up_arready, up_rvalid;
  logic [1:0][1:0]    up_bresp, up_rresp;
  logic [1:0][DW-1:0] up_rdata;
  // slave-side stimulus and DUT downstream outputs
  logic               s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]         s_bresp, s_rresp;
  logic [DW-1:0]      s_rdata;
  logic [AW-1:0]      dn_awaddr, dn_araddr;
  logic [2:0]         dn_awprot, dn_arprot;
  logic [DW-1:0]      dn_wdata;
  logic [3:0]         dn_wstrb;
  logic               dn_awvalid, dn_wvalid, dn_bready, dn_arvalid, dn_rready;
  logic [1:0]         grant;
  logic               busy;

  axi_mmio_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .aclk(aclk), .arst_n(arst_n),
    .M_AXI_awaddr(m_awaddr), .M_AXI_awprot(m_awprot), .M_AXI_awvalid(m_awvalid), .M_AXI_awready(up_awready),
    .M_AXI_wdata(m_wdata), .M_AXI_wstrb(m_wstrb), .M_AXI_wvalid(m_wvalid), .M_AXI_wready(up_wready),
    .M_AXI_bresp(up_bresp), .M_AXI_bvalid(up_bvalid), .M_AXI_bready(m_bready),
    .M_AXI_araddr(m_araddr), .M_AXI_arprot(m_arprot), .M_AXI_arvalid(m_arvalid), .M_AXI_arready(up_arready),
    .M_AXI_rdata(up_rdata), .M_AXI_rresp(up_rresp), .M_AXI_rvalid(up_rvalid), .M_AXI_rready(m_rready),
    .S_AXI_awaddr(dn_awaddr), .S_AXI_awprot(dn_awprot), .S_AXI_awvalid(dn_awvalid), .S_AXI_awready(s_awready),
    .S_AXI_wdata(dn_wdata), .S_AXI_wstrb(dn_wstrb), .S_AXI_wvalid(dn_wvalid), .S_AXI_wready(s_wready),
    .S_AXI_bresp(s_bresp), .S_AXI_bvalid(s_bvalid), .S_AXI_bready(dn_bready),
    .S_AXI_araddr(dn_araddr), .S_AXI_arprot(dn_arprot), .S_AXI_arvalid(dn_arvalid), .S_AXI_arready(s_arready),
    .S_AXI_rdata(s_rdata), .S_AXI_rresp(s_rresp), .S_AXI_rvalid(s_rvalid), .S_AXI_rready(dn_rready),
    .grant(grant), .busy(busy)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] ctl_vec();
    return {grant, busy, up_awready, up_wready, up_bvalid, up_arready, up_rvalid,
            dn_awvalid, dn_wvalid, dn_arvalid, dn_bready, dn_rready};
  endfunction

  // ---------------- transaction-level reference model ----------------
  int own = -1;          // master owning the port, -1 when the port is free
  int last = 1;          // previous owner, decides ties
  bit wr, need_aw, need_w, in_resp;
  bit r0, r1;

  logic [1:0]         eg, e_mawr, e_mwr, e_marr, e_mbv, e_mrv;
  logic               ebusy, e_sawv, e_swv, e_sarv, e_sbr, e_srr;
  logic [1:0][1:0]    e_mbresp, e_mrresp;
  logic [1:0][DW-1:0] e_mrdata;
  logic [AW-1:0]      e_awaddr, e_araddr;
  logic [2:0]         e_awprot, e_arprot;
  logic [DW-1:0]      e_wdata;
  logic [3:0]         e_wstrb;

  // Every falling edge: derive what the outputs must be from the owner and its remaining phases, compare, then advance
  always @(negedge aclk) begin
    if (!arst_n) begin
      own = -1; last = 1; wr = 0; need_aw = 0; need_w = 0; in_resp = 0;
    end
    eg = 0; ebusy = 0; e_mawr = 0; e_mwr = 0; e_marr = 0; e_mbv = 0; e_mrv = 0;
    e_sawv = 0; e_swv = 0; e_sarv = 0; e_sbr = 0; e_srr = 0;
    e_mbresp = 0; e_mrresp = 0; e_mrdata = 0;
    e_awaddr = 0; e_araddr = 0; e_awprot = 0; e_arprot = 0; e_wdata = 0; e_wstrb = 0;
    if (own >= 0) begin
      eg = (own == 1) ? 2'b10 : 2'b01;
      ebusy = 1;
      e_awaddr = m_awaddr[own]; e_awprot = m_awprot[own];
      e_wdata = m_wdata[own];   e_wstrb = m_wstrb[own];
      e_araddr = m_araddr[own]; e_arprot = m_arprot[own];
      if (wr && !in_resp) begin
        e_sawv = m_awvalid[own] & need_aw;
        e_swv  = m_wvalid[own] & need_w;
        e_mawr[own] = s_awready & need_aw;
        e_mwr[own]  = s_wready & need_w;
      end else if (wr) begin
        e_mbv[own] = s_bvalid; e_mbresp[own] = s_bresp; e_sbr = m_bready[own];
      end else if (!in_resp) begin
        e_sarv = m_arvalid[own]; e_marr[own] = s_arready;
      end else begin
        e_mrv[own] = s_rvalid; e_mrdata[own] = s_rdata; e_mrresp[own] = s_rresp; e_srr = m_rready[own];
      end
    end
    chk("ctl", {grant, busy, dn_awvalid, dn_wvalid, dn_arvalid, dn_bready, dn_rready},
               {eg, ebusy, e_sawv, e_swv, e_sarv, e_sbr, e_srr});
    chk("up_hs", {up_awready, up_wready, up_arready, up_bvalid, up_rvalid},
                 {e_mawr, e_mwr, e_marr, e_mbv, e_mrv});
    chk("dn_payload", {dn_awaddr, dn_awprot, dn_wdata, dn_wstrb, dn_araddr, dn_arprot},
                      {e_awaddr, e_awprot, e_wdata, e_wstrb, e_araddr, e_arprot});
    chk("up_resp", {up_bresp, up_rdata, up_rresp}, {e_mbresp, e_mrdata, e_mrresp});
    if (arst_n) begin
      if (own < 0) begin
        r0 = m_awvalid[0] | m_arvalid[0];
        r1 = m_awvalid[1] | m_arvalid[1];
        if (r0 || r1) begin
          own = (r0 && r1) ? (1 - last) : (r0 ? 0 : 1);
          wr = m_awvalid[own]; need_aw = 1; need_w = 1; in_resp = 0;
        end
      end else if (wr && !in_resp) begin
        if (e_sawv && s_awready) need_aw = 0;
        if (e_swv && s_wready) need_w = 0;
        if (!need_aw && !need_w) in_resp = 1;
      end else if (in_resp) begin
        if (wr ? (s_bvalid & m_bready[own]) : (s_rvalid & m_rready[own])) begin
          last = own; own = -1;
        end
      end else if (m_arvalid[own] && s_arready) begin
        in_resp = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge aclk); #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    m_awaddr = 0; m_araddr = 0; m_awprot = 0; m_arprot = 0; m_wdata = 0; m_wstrb = 0;
    m_awvalid = 0; m_wvalid = 0; m_bready = 0; m_arvalid = 0; m_rready = 0;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_arready = 0; s_rvalid = 0;
    s_bresp = 0; s_rresp = 0; s_rdata = 0;
  endtask

  bit aw_v[2], w_v[2], ar_v[2], wait_b[2], wait_r[2];
  logic [31:0] exp_rd[2];
  bit sl_aw, sl_w, sl_b, sl_r;
  logic [31:0] sl_rd;
  logic [1:0] sl_rr;
  logic [1:0] exp_g [3];
  int g, wh, op, drained;

  initial begin
    clear_inputs();
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
    arst_n = 0;
    repeat (3) @(posedge aclk);
    #2;
    chk("reset_outputs", ctl_vec(), 0);
    @(posedge aclk); #1 arst_n = 1;

    // three rounds of simultaneous reads alternate between the masters
    m_araddr[0] = 32'h1000_0010; m_araddr[1] = 32'h2000_0020; m_rready = 2'b11;
    m_arvalid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      g = exp_g[k][1] ? 1 : 0;
      tick(); settle();
      chk("rr_grant", grant, exp_g[k]);
      s_arready = 1;
      tick();
      s_arready = 0; m_arvalid[g] = 0; s_rvalid = 1; s_rdata = m_araddr[g] ^ KEY;
      settle();
      chk("rr_rdata", up_rdata[g], m_araddr[g] ^ KEY);
      chk("rr_rvalid", up_rvalid, exp_g[k]);
      tick();
      s_rvalid = 0; s_rdata = 0;
      if (k < 2) m_arvalid[g] = 1; else m_arvalid = 0;
    end

    // single write from master 0 with OKAY response
    m_awaddr[0] = 32'h4600_0104; m_wdata[0] = 32'hDEAD_BEEF; m_wstrb[0] = 4'hF;
    m_awvalid[0] = 1; m_wvalid[0] = 1; m_bready = 2'b11;
    settle();
    chk("idle_no_ready", {up_awready, up_wready, up_arready}, 0);
    tick(); settle();
    chk("wr_grant", grant, 2'b01);
    chk("wr_awaddr", dn_awaddr, 32'h4600_0104);
    chk("wr_wdata", dn_wdata, 32'hDEAD_BEEF);
    s_awready = 1; s_wready = 1;
    settle();
    chk("wr_m0_ready", {up_awready, up_wready}, 4'b0101);
    tick();
    m_awvalid[0] = 0; m_wvalid[0] = 0; s_awready = 0; s_wready = 0; s_bvalid = 1; s_bresp = 2'b00;
    settle();
    chk("wr_bvalid", up_bvalid, 2'b01);
    chk("wr_bresp", up_bresp[0], 2'b00);
    chk("m1_untouched", {up_awready[1], up_wready[1], up_bvalid[1], up_arready[1], up_rvalid[1]}, 0);
    tick();
    s_bvalid = 0;
    settle();
    chk("wr_done_idle", {grant, busy}, 0);

    // master 1 presents write and read together: write first, one idle cycle, then read
    m_awaddr[1] = 32'h3000_0030; m_wdata[1] = 32'h1234_5678; m_wstrb[1] = 4'h3;
    m_araddr[1] = 32'h3000_0034;
    m_awvalid[1] = 1; m_wvalid[1] = 1; m_arvalid[1] = 1;
    tick(); settle();
    chk("wfirst_grant", grant, 2'b10);
    chk("wfirst_valids", {dn_awvalid, dn_wvalid, dn_arvalid}, 3'b110);
    s_awready = 1; s_wready = 1;
    tick();
    m_awvalid[1] = 0; m_wvalid[1] = 0; s_awready = 0; s_wready = 0; s_bvalid = 1;
    tick();
    s_bvalid = 0;
    settle();
    chk("turnaround_idle", {grant, busy, dn_arvalid}, 0);
    tick(); settle();
    chk("rd_after_wr", {grant, dn_arvalid, dn_araddr}, {2'b10, 1'b1, 32'h3000_0034});
    s_arready = 1;
    tick();
    s_arready = 0; m_arvalid[1] = 0; s_rvalid = 1; s_rdata = 32'h3000_0034 ^ KEY;
    settle();
    chk("m1_rdata", up_rdata[1], 32'h3000_0034 ^ KEY);
    tick();
    s_rvalid = 0; s_rdata = 0;

    // slave takes w two cycles before aw; master keeps wvalid high to probe the done mask
    wh = 0;
    m_awaddr[0] = 32'h4600_0200; m_wdata[0] = 32'hCAFE_F00D; m_awvalid[0] = 1; m_wvalid[0] = 1;
    tick();
    s_wready = 1;
    settle(); wh += int'(dn_wvalid && s_wready);
    tick(); settle(); wh += int'(dn_wvalid && s_wready);
    tick();
    s_awready = 1;
    settle(); wh += int'(dn_wvalid && s_wready);
    chk("aw_late_still_addr", {dn_awvalid, dn_bready}, 2'b10);
    tick();
    s_awready = 0; s_wready = 0; m_awvalid[0] = 0; m_wvalid[0] = 0; s_bvalid = 1; s_bresp = 2'b10;
    settle();
    chk("w_once", wh, 1);
    chk("slverr_fwd", {up_bvalid, up_bresp[0], dn_bready}, {2'b01, 2'b10, 1'b1});
    tick();
    s_bvalid = 0; s_bresp = 0;

    // awvalid withdrawn before its handshake: state holds, nothing leaks downstream
    m_awaddr[0] = 32'h4600_0300; m_awvalid[0] = 1;
    tick(); settle();
    chk("viol_grant", grant, 2'b01);
    m_awvalid[0] = 0;
    settle();
    chk("viol_no_valid", {dn_awvalid, dn_wvalid}, 0);
    tick(); settle();
    chk("viol_hold", {grant, busy}, 3'b011);
    m_awvalid[0] = 1; m_wvalid[0] = 1; s_awready = 1; s_wready = 1;
    tick();
    m_awvalid[0] = 0; m_wvalid[0] = 0; s_awready = 0; s_wready = 0; s_bvalid = 1;
    tick();
    s_bvalid = 0;

    // reset during a read response, then a tie must go to master 0
    m_araddr[0] = 32'h5000_0000; m_arvalid[0] = 1; m_rready = 2'b00;
    tick();
    s_arready = 1;
    tick();
    s_arready = 0; m_arvalid[0] = 0; s_rvalid = 1; s_rdata = 32'h5000_0000 ^ KEY;
    settle();
    chk("rd_resp_pending", up_rvalid, 2'b01);
    #1 arst_n = 0;
    #1 chk("async_reset_outputs", ctl_vec(), 0);
    s_rvalid = 0; s_rdata = 0;
    @(posedge aclk); #1 arst_n = 1;
    m_araddr[0] = 32'h5000_0040; m_araddr[1] = 32'h5000_0080; m_arvalid = 2'b11; m_rready = 2'b11;
    tick(); settle();
    chk("post_reset_grant", grant, 2'b01);
    s_arready = 1;
    tick();
    s_arready = 0; m_arvalid[0] = 0; s_rvalid = 1; s_rdata = m_araddr[0] ^ KEY;
    tick();
    s_rvalid = 0;
    tick();
    s_arready = 1;
    tick();
    s_arready = 0; m_arvalid[1] = 0; s_rvalid = 1; s_rdata = m_araddr[1] ^ KEY;
    tick();
    s_rvalid = 0; s_rdata = 0;

    // randomized traffic from both masters against a randomly stalling slave
    drained = 0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge aclk); #1;
      for (int i = 0; i < 2; i++) begin
        if (c < 3000 && !(aw_v[i] | w_v[i] | ar_v[i] | wait_b[i] | wait_r[i]) && $urandom_range(3) == 0) begin
          op = $urandom_range(2);
          if (op != 1) begin
            aw_v[i] = 1; w_v[i] = 1; wait_b[i] = 1;
            m_awaddr[i] = $urandom; m_awprot[i] = 3'($urandom);
            m_wdata[i] = $urandom;  m_wstrb[i] = 4'($urandom);
          end
          if (op != 0) begin
            ar_v[i] = 1; wait_r[i] = 1;
            m_araddr[i] = $urandom; m_arprot[i] = 3'($urandom);
            exp_rd[i] = m_araddr[i] ^ KEY;
          end
        end
        m_awvalid[i] = aw_v[i]; m_wvalid[i] = w_v[i]; m_arvalid[i] = ar_v[i];
        m_bready[i] = ($urandom_range(3) != 0);
        m_rready[i] = ($urandom_range(3) != 0);
      end
      if (sl_aw && sl_w) begin
        sl_aw = 0; sl_w = 0; sl_b = 1;
        s_bresp = ($urandom_range(1) == 1) ? 2'b10 : 2'b00;
      end
      s_bvalid = sl_b;
      s_rvalid = sl_r; s_rdata = sl_r ? sl_rd : 32'h0; s_rresp = sl_rr;
      s_awready = !sl_aw && ($urandom_range(1) == 1);
      s_wready  = !sl_w && ($urandom_range(1) == 1);
      s_arready = !sl_r && ($urandom_range(1) == 1);
      @(negedge aclk); #1;
      for (int i = 0; i < 2; i++) begin
        if (m_awvalid[i] && up_awready[i]) aw_v[i] = 0;
        if (m_wvalid[i] && up_wready[i]) w_v[i] = 0;
        if (m_arvalid[i] && up_arready[i]) ar_v[i] = 0;
        if (up_bvalid[i] && m_bready[i]) wait_b[i] = 0;
        if (up_rvalid[i] && m_rready[i]) begin
          wait_r[i] = 0;
          chk("rnd_rdata_owner", up_rdata[i], exp_rd[i]);
        end
      end
      if (dn_awvalid && s_awready) sl_aw = 1;
      if (dn_wvalid && s_wready) sl_w = 1;
      if (dn_arvalid && s_arready) begin
        sl_r = 1; sl_rd = dn_araddr ^ KEY;
        sl_rr = ($urandom_range(1) == 1) ? 2'b10 : 2'b00;
      end
      if (s_bvalid && dn_bready) sl_b = 0;
      if (s_rvalid && dn_rready) sl_r = 0;
      if (c >= 3000 && !(aw_v[0] | w_v[0] | ar_v[0] | wait_b[0] | wait_r[0] |
                         aw_v[1] | w_v[1] | ar_v[1] | wait_b[1] | wait_r[1] | sl_b | sl_r | busy)) begin
        drained = 1;
        break;
      end
    end
    chk("drain_idle", drained, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
